// File: rtl/serial_cascade_engine.sv
// Bit-serial sequencer for the generic cascade cell: walks two operands LSB-first,
// chaining K_out into the next K_in, and returns the collected U word over valid/ready.
module serial_cascade_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             k_init,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             k_final,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             en_r;
  logic             k_r;
  logic             k_final_r;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_bit;
  logic [1:0]       cell_out;

  // Returns {K_out, U}; with the enable low the cell passes X and K straight through.
  function automatic logic [1:0] cascade_cell(input logic e, input logic x,
                                              input logic y, input logic k);
    logic [1:0] r;
    if (e) begin
      r = {(x & y) | (k & (x ^ y)), x ^ y ^ k};
    end else begin
      r = {k, x};
    end
    return r;
  endfunction

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (cnt == LAST_CNT);
  assign cell_out = cascade_cell(en_r, a_r[cnt], b_r[cnt], k_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are frozen at accept so later input activity cannot disturb the walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      en_r      <= 1'b0;
      k_r       <= 1'b0;
      cnt       <= '0;
      result_r  <= '0;
      k_final_r <= 1'b0;
    end else if (accept) begin
      a_r       <= op_a;
      b_r       <= op_b;
      en_r      <= en;
      k_r       <= k_init;
      cnt       <= '0;
      result_r  <= '0;
      k_final_r <= 1'b0;
    end else if (state == RUN) begin
      result_r[cnt] <= cell_out[0];
      k_r           <= cell_out[1];
      if (last_bit) begin
        k_final_r <= cell_out[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign result    = result_r;
  assign k_final   = k_final_r;

endmodule

// File: tb/tb_serial_cascade_engine.sv
// Self-checking bench for serial_cascade_engine: vector table plus scoreboard,
// with hand-written sequences for output stall and mid-operation reset.
module tb_serial_cascade_engine;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             k_init;
  logic             en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             k_final;
  logic             busy;

  serial_cascade_engine #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .k_init    (k_init),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .k_final   (k_final),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             k;
    logic             e;
    logic [WIDTH-1:0] res;
    logic             kf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             kf;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: enabled cell chain is a ripple add; disabled chain passes X and K.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic k, input logic e);
    logic [WIDTH:0] s;
    if (e) s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, k};
    else   s = {k, a};
    return s;
  endfunction

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic k, input logic e);
    exp_t x;
    logic [WIDTH:0] m;
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    op_a = a; op_b = b; k_init = k; en = e; in_valid = 1'b1;
    m = model(a, b, k, e);
    x.res = m[WIDTH-1:0];
    x.kf  = m[WIDTH];
    sb.push_back(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; k_init = ~k; en = ~e;
  endtask

  // Call right after start_op; counts negedges until out_valid and checks the scoreboard.
  task automatic wait_done();
    int   lat;
    exp_t x;
    lat = -1;
    for (int i = 0; i < WIDTH + 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (!busy) begin
        total++; bad++;
        $display("FAIL busy_in_run: got 0 expected 1 at step %0d", i);
      end
    end
    chk("latency", lat, WIDTH);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got output expected none");
    end else begin
      x = sb.pop_front();
      chk("result", {24'd0, result}, {24'd0, x.res});
      chk("k_final", {31'd0, k_final}, {31'd0, x.kf});
    end
  endtask

  task automatic finish_xfer();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_xfer_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_after_xfer_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rk;
    exp_t             dropped;

    vecs[0] = '{a: 8'h5A, b: 8'h33, k: 1'b0, e: 1'b1, res: 8'h8D, kf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, k: 1'b0, e: 1'b1, res: 8'h00, kf: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h00, k: 1'b1, e: 1'b1, res: 8'h01, kf: 1'b0};
    vecs[3] = '{a: 8'hC3, b: 8'hFF, k: 1'b1, e: 1'b0, res: 8'hC3, kf: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, k: 1'b1, e: 1'b1, res: 8'hFF, kf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, k: 1'b0, e: 1'b1, res: 8'h00, kf: 1'b1};

    in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; k_init = 1'b0; en = 1'b0;

    // Reset values, then quiet idle after release
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_k_final", {31'd0, k_final}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_result", {24'd0, result}, 32'd0);

    // Table vectors; the table constants must also agree with the model
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH:0] m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].e);
      start_op(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].e);
      wait_done();
      chk("table_result", {24'd0, result}, {24'd0, vecs[i].res});
      chk("table_k_final", {31'd0, k_final}, {31'd0, vecs[i].kf});
      chk("table_vs_model", {23'd0, m}, {23'd0, vecs[i].kf, vecs[i].res});
      finish_xfer();
    end

    // Random operations through the scoreboard
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rk = 1'($urandom);
      start_op(ra, rb, rk, (i % 4) != 3);
      wait_done();
      finish_xfer();
    end

    // Output stall: result held, new in_valid ignored
    start_op(8'h5A, 8'h33, 1'b0, 1'b1);
    wait_done();
    held = result;
    for (int i = 0; i < 5; i++) begin
      op_a = 8'hA5 + WIDTH'(i); op_b = 8'h11; k_init = 1'b1; en = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_result", {24'd0, result}, {24'd0, held});
    end
    in_valid = 1'b0;
    chk("stall_result_value", {24'd0, held}, 32'h8D);
    finish_xfer();
    start_op(8'h01, 8'h01, 1'b0, 1'b1);
    wait_done();
    chk("after_stall_result", {24'd0, result}, 32'h02);
    finish_xfer();

    // Reset during RUN discards the operation
    start_op(8'h5A, 8'h33, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", {24'd0, result}, 32'd0);
    chk("midrst_k_final", {31'd0, k_final}, 32'd0);
    if (sb.size() != 0) dropped = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done();
    chk("post_rst_result", {24'd0, result}, 32'h30);
    chk("post_rst_k_final", {31'd0, k_final}, 32'd0);
    finish_xfer();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_cascade_engine.md
# serial_cascade_engine

Bit-serial sequencer for the lab's generic cascade cell (En, X, Y, K_in -> U, K_out). It accepts two WIDTH-bit operands and an initial cascade bit through a valid/ready handshake. It then drives the cell LSB-first, one bit per clock, feeding each K_out back as the next K_in, and collects the U bits into a result word. The result is returned through a second valid/ready handshake. It is the clocked consumer side of the cell that the lab otherwise exercises only with exhaustive static vectors.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  engine can accept; high only in IDLE.
- op_a  input  WIDTH  X operand, sampled on accept.
- op_b  input  WIDTH  Y operand, sampled on accept.
- k_init  input  1  initial K_in, sampled on accept.
- en  input  1  cell enable for the whole operation, sampled on accept.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  collected U bits; bit i is the U from step i.
- k_final  output  1  K_out of the final (MSB) step.
- busy  output  1  high in RUN.

## Operation
- Cell function with en=1: U = X^Y^K, K_out = (X&Y)|(K&(X^Y)).
- Cell function with en=0: U = X, K_out = K (pass-through).
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, capture op_a, op_b, k_init and en into internal registers; clear the bit counter to 0; clear the result register; go to RUN.
- RUN, each cycle: apply the cell to bit[cnt] of a and b with the current K register. Write U into result[cnt] and K_out into the K register. Increment cnt.
- RUN exit: when cnt = WIDTH-1 is processed, go to DONE and latch k_final from that step's K_out.
- DONE: out_valid=1. result and k_final are held stable. On out_ready, go to IDLE.
- in_valid in RUN or DONE is ignored: in_ready=0, and no operand registers change.
- Operand registers are internal. Input changes after accept have no effect on the running operation.
- The counter is wide enough to hold WIDTH-1 (clog2). It does not wrap within an operation.
- Reset clears all state at any time, including mid-RUN or in DONE. The partial result is discarded.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, k_final=0, counter=0, K register=0.
- The accept edge is T. RUN occupies cycles T+1 through T+WIDTH.
- DONE is entered on edge T+WIDTH, so out_valid is high from that edge onward.
- Latency from accept to out_valid is WIDTH clocks.
- out_valid and result are held for as long as out_ready=0. There is no timeout.
- A transfer completes on the edge where out_valid && out_ready; state becomes IDLE on that edge.
- in_ready rises the same edge the transfer completes. The earliest next accept is the following edge.
- Back-to-back throughput is one operation per WIDTH+2 clocks when out_ready is held high.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Asynchronous reset takes effect immediately. Release is synchronized by the system; the block only needs the first post-reset edge to behave as IDLE.

## Test plan
- Reset value check: assert rst_n=0 -> in_ready=1, out_valid=0, busy=0, result=0x00, k_final=0. Release, then check that nothing changes with in_valid=0.
- Basic add: WIDTH=8, op_a=0x5A, op_b=0x33, k_init=0, en=1 -> out_valid exactly 8 clocks after accept, result=0x8D, k_final=0.
- Full carry ripple: op_a=0xFF, op_b=0x01, k_init=0, en=1 -> result=0x00, k_final=1. Repeat with op_a=0x00, op_b=0x00, k_init=1 -> result=0x01, k_final=0.
- Pass-through: en=0, op_a=0xC3, op_b=0xFF, k_init=1 -> result=0xC3, k_final=1.
- Handshake: hold out_ready=0 for 5 clocks in DONE -> result stays stable, and in_valid pulses with new operands are ignored. Raise out_ready -> IDLE on the next edge. Next accept of 0x01+0x01 gives 0x02.
- Reset mid-op: accept 0x5A+0x33, assert rst_n=0 at cycle T+4 -> immediate return to IDLE with all outputs at reset values. A new op 0x10+0x20 then gives 0x30 and k_final=0.
